// File: rtl/ro_meas_ctrl_pkg.sv
// Shared types and default constants for the ring-oscillator measurement controller.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    typedef logic [15:0] window_t;

    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// Signal bundle between a measurement requester and ro_meas_ctrl.
interface ro_meas_ctrl_if
    import ro_meas_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic             abort;
    window_t          window_len;
    logic             ro_tap;
    logic             ro_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] result;
    logic             overflow;

    modport master (
        output start, abort, window_len, ro_tap,
        input  ro_en, busy, done, result, overflow
    );

    modport slave (
        input  start, abort, window_len, ro_tap,
        output ro_en, busy, done, result, overflow
    );

endinterface

// File: rtl/ro_sync_edge.sv
// Multi-flop synchronizer followed by a free-running rising-edge detector.
module ro_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q[0] <= async_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator frequency measurement: enable, settle, count edges over a window.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  window_t          window_len,
    input  logic             ro_tap,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             overflow
);

    localparam window_t SETTLE_LOAD = (SETTLE_CYCLES == 0) ? '0 : window_t'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    window_t          tmr_q, tmr_d;
    window_t          win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             clr;
    logic             rise;

    ro_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_in(ro_tap),
        .rise    (rise)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        win_d   = win_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (window_len != '0)) begin
                    win_d = window_len;
                    clr   = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = ST_MEASURE;
                        tmr_d   = window_len - window_t'(1);
                    end else begin
                        state_d = ST_SETTLE;
                        tmr_d   = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    state_d = ST_MEASURE;
                    tmr_d   = win_q - window_t'(1);
                end else begin
                    tmr_d = tmr_q - window_t'(1);
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - window_t'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating edge counter; the final MEASURE cycle's edge is folded into result via cnt_d.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == ST_MEASURE) && rise) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ro_en   <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
            busy    <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
            done    <= (state_d == ST_DONE);
            if ((state_q == ST_MEASURE) && (state_d == ST_DONE)) begin
                result   <= cnt_d;
                overflow <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: default build plus an 8-bit-counter build.
module tb_ro_meas_ctrl;
    import ro_meas_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ro_meas_ctrl_if #(.CNT_W(16)) bus ();
    ro_meas_ctrl_if #(.CNT_W(8))  bus8 ();

    ro_meas_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.start),
        .abort     (bus.abort),
        .window_len(bus.window_len),
        .ro_tap    (bus.ro_tap),
        .ro_en     (bus.ro_en),
        .busy      (bus.busy),
        .done      (bus.done),
        .result    (bus.result),
        .overflow  (bus.overflow)
    );

    ro_meas_ctrl #(
        .CNT_W(8)
    ) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (bus8.start),
        .abort     (bus8.abort),
        .window_len(bus8.window_len),
        .ro_tap    (bus8.ro_tap),
        .ro_en     (bus8.ro_en),
        .busy      (bus8.busy),
        .done      (bus8.done),
        .result    (bus8.result),
        .overflow  (bus8.overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator taps offset from the clock edges: period 4 clk and period 2 clk.
    initial begin
        bus.ro_tap = 1'b0;
        #3;
        forever #20 bus.ro_tap = ~bus.ro_tap;
    end

    initial begin
        bus8.ro_tap = 1'b0;
        #3;
        forever #10 bus8.ro_tap = ~bus8.ro_tap;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        n_tests++;
        assert ((obs >= 32'(lo)) && (obs <= 32'(hi))) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    int   done_at;
    int   done2_at;
    int   done_cnt;
    int   en_cnt;
    int   act_cnt;
    logic busy1;
    logic en49;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start = 1'b0;  bus.abort = 1'b0;  bus.window_len = '0;
        bus8.start = 1'b0; bus8.abort = 1'b0; bus8.window_len = '0;
        #22;
        rst = 1'b0;
        step();

        chk("rst_ro_en",    32'(bus.ro_en),    0);
        chk("rst_busy",     32'(bus.busy),     0);
        chk("rst_done",     32'(bus.done),     0);
        chk("rst_result",   32'(bus.result),   0);
        chk("rst_overflow", 32'(bus.overflow), 0);

        // Basic run; start and abort together in IDLE, window change after acceptance.
        bus.window_len = 16'd100; bus.start = 1'b1; bus.abort = 1'b1;
        done_at = 0; done_cnt = 0; en_cnt = 0; busy1 = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            step();
            if (n == 1) begin
                busy1 = bus.busy;
                bus.start = 1'b0; bus.abort = 1'b0; bus.window_len = 16'd5;
            end
            if (bus.ro_en) en_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
        end
        chk("start_wins_busy", 32'(busy1), 1);
        chk("latency_109", 32'(done_at), 109);
        chk("done_count_1", 32'(done_cnt), 1);
        chk("ro_en_cycles", 32'(en_cnt), 108);
        chk_rng("result_25", 32'(bus.result), 24, 26);
        chk("overflow_0", 32'(bus.overflow), 0);
        chk("idle_after", 32'(bus.busy), 0);

        // Abort in the middle of the window.
        bus.window_len = 16'd100; bus.start = 1'b1;
        en49 = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            step();
            if (n == 1) bus.start = 1'b0;
            if (n == 49) begin
                en49 = bus.ro_en;
                bus.abort = 1'b1;
            end
        end
        chk("abort_pre_en", 32'(en49), 1);
        chk("abort_ro_en", 32'(bus.ro_en), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        bus.abort = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 120; n++) begin
            step();
            if (bus.done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 0);
        chk_rng("abort_result_kept", 32'(bus.result), 24, 26);
        chk("abort_ovf_kept", 32'(bus.overflow), 0);

        // Zero-length window is ignored.
        bus.window_len = '0; bus.start = 1'b1;
        act_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 1) bus.start = 1'b0;
            if (bus.ro_en || bus.busy || bus.done) act_cnt++;
        end
        chk("win0_inactive", 32'(act_cnt), 0);

        // Shortest window.
        bus.window_len = 16'd1; bus.start = 1'b1;
        done_at = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 1) bus.start = 1'b0;
            if (bus.done && (done_at == 0)) done_at = n;
        end
        chk("win1_latency", 32'(done_at), 10);

        // start held high: back-to-back runs, 30-cycle spacing.
        bus.window_len = 16'd20; bus.start = 1'b1;
        done_at = 0; done2_at = 0; done_cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
                else if (done2_at == 0) done2_at = n;
            end
        end
        bus.start = 1'b0;
        chk("b2b_first", 32'(done_at), 29);
        chk("b2b_second", 32'(done2_at), 59);
        chk("b2b_count", 32'(done_cnt), 2);
        chk_rng("b2b_result", 32'(bus.result), 4, 6);
        for (int n = 0; n < 40; n++) step();

        // 8-bit counter saturation, then a normal short run.
        bus8.window_len = 16'd1000; bus8.start = 1'b1;
        done_at = 0;
        for (int n = 1; n <= 1020; n++) begin
            step();
            if (n == 1) bus8.start = 1'b0;
            if (bus8.done && (done_at == 0)) done_at = n;
        end
        chk("sat_latency", 32'(done_at), 1009);
        chk("sat_result", 32'(bus8.result), 255);
        chk("sat_overflow", 32'(bus8.overflow), 1);
        bus8.window_len = 16'd10; bus8.start = 1'b1;
        done_at = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 1) bus8.start = 1'b0;
            if (bus8.done && (done_at == 0)) done_at = n;
        end
        chk("short_latency", 32'(done_at), 19);
        chk_rng("short_result", 32'(bus8.result), 4, 6);
        chk("short_overflow", 32'(bus8.overflow), 0);

        // Asynchronous reset mid-MEASURE, then a normal run.
        bus.window_len = 16'd100; bus.start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 1) bus.start = 1'b0;
        end
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ro_en",    32'(bus.ro_en),    0);
        chk("arst_busy",     32'(bus.busy),     0);
        chk("arst_result",   32'(bus.result),   0);
        chk("arst_overflow", 32'(bus.overflow), 0);
        #2;
        rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (bus.done) done_cnt++;
        end
        chk("arst_no_done", 32'(done_cnt), 0);
        bus.start = 1'b1;
        done_at = 0;
        for (int n = 1; n <= 120; n++) begin
            step();
            if (n == 1) bus.start = 1'b0;
            if (bus.done && (done_at == 0)) done_at = n;
        end
        chk("post_rst_latency", 32'(done_at), 109);
        chk_rng("post_rst_result", 32'(bus.result), 24, 26);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
